// File: rtl/ovf_trap_pkg.sv
// Shared constants and state encoding for the overflow trap controller.
package ovf_trap_pkg;

  // Controller states, binary encoded.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } trap_state_t;

  localparam int unsigned PC_WIDTH_DEFAULT    = 32;
  localparam int unsigned CNT_WIDTH_DEFAULT   = 8;
  localparam logic [31:0] HANDLER_VEC_DEFAULT = 32'h0000_0180;

  // Exception cause code for arithmetic overflow.
  localparam logic [4:0] EXC_OV = 5'd12;

  // ERET resumes at the instruction after the faulting one.
  localparam int unsigned ERET_OFFSET = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ovf_trap_ctrl.sv
// Precise arithmetic-overflow exception controller beside the EX stage.
module ovf_trap_ctrl
  import ovf_trap_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0]  HANDLER_VEC = PC_WIDTH'(HANDLER_VEC_DEFAULT),
  parameter int unsigned          CNT_WIDTH   = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_ovf,
  input  logic                 ex_ovf_en,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_eret,
  input  logic                 stall,
  output logic                 kill_ex_wb,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic [PC_WIDTH-1:0]  epc,
  output logic                 cause_ovf,
  output logic                 exl,
  output logic                 double_fault,
  output logic [CNT_WIDTH-1:0] trap_cnt
);

  trap_state_t         state, state_nxt;
  logic                ovf_hit;
  logic                trap_inc;
  logic                redirect_valid_nxt;
  logic [PC_WIDTH-1:0] redirect_pc_nxt;
  logic                flush_if_id_nxt, flush_id_ex_nxt, flush_ex_mem_nxt;
  logic [PC_WIDTH-1:0] epc_nxt;
  logic                cause_ovf_nxt, exl_nxt, double_fault_nxt;

  // Overflow on a trapping op; suppresses writeback even while stalled.
  assign ovf_hit    = ex_valid & ex_ovf & ex_ovf_en;
  assign kill_ex_wb = ovf_hit;

  // Next state plus the strobes/architectural state for the coming cycle.
  always_comb begin
    state_nxt          = state;
    redirect_valid_nxt = 1'b0;
    redirect_pc_nxt    = '0;
    flush_if_id_nxt    = 1'b0;
    flush_id_ex_nxt    = 1'b0;
    flush_ex_mem_nxt   = 1'b0;
    epc_nxt            = epc;
    cause_ovf_nxt      = cause_ovf;
    exl_nxt            = exl;
    double_fault_nxt   = double_fault;
    trap_inc           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ovf_hit && !stall) begin
          state_nxt          = ST_TRAP;
          epc_nxt            = ex_pc;
          cause_ovf_nxt      = 1'b1;
          exl_nxt            = 1'b1;
          trap_inc           = 1'b1;
          redirect_valid_nxt = 1'b1;
          redirect_pc_nxt    = HANDLER_VEC;
          flush_if_id_nxt    = 1'b1;
          flush_id_ex_nxt    = 1'b1;
          flush_ex_mem_nxt   = 1'b1;
        end
      end
      ST_TRAP: begin
        state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (ovf_hit) begin
          double_fault_nxt = 1'b1;
        end
        if (ex_valid && ex_eret && !stall) begin
          state_nxt          = ST_RETURN;
          redirect_valid_nxt = 1'b1;
          redirect_pc_nxt    = epc + PC_WIDTH'(ERET_OFFSET);
          flush_if_id_nxt    = 1'b1;
          flush_id_ex_nxt    = 1'b1;
        end
      end
      ST_RETURN: begin
        state_nxt = ST_IDLE;
        exl_nxt   = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, strobe and exception-record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      flush_ex_mem   <= 1'b0;
      epc            <= '0;
      cause_ovf      <= 1'b0;
      exl            <= 1'b0;
      double_fault   <= 1'b0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      flush_if_id    <= flush_if_id_nxt;
      flush_id_ex    <= flush_id_ex_nxt;
      flush_ex_mem   <= flush_ex_mem_nxt;
      epc            <= epc_nxt;
      cause_ovf      <= cause_ovf_nxt;
      exl            <= exl_nxt;
      double_fault   <= double_fault_nxt;
    end
  end

  // Count of taken traps, saturating.
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_trap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (trap_inc),
    .count (trap_cnt)
  );

endmodule

// File: tb/tb_ovf_trap_ctrl.sv
// Directed self-checking bench for ovf_trap_ctrl.
module tb_ovf_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0, ex_ovf = 1'b0, ex_ovf_en = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        ex_eret = 1'b0, stall = 1'b0;
  logic        kill_ex_wb, redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [31:0] redirect_pc, epc;
  logic        cause_ovf, exl, double_fault;
  logic [7:0]  trap_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ovf_trap_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ovf         (ex_ovf),
    .ex_ovf_en      (ex_ovf_en),
    .ex_pc          (ex_pc),
    .ex_eret        (ex_eret),
    .stall          (stall),
    .kill_ex_wb     (kill_ex_wb),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .epc            (epc),
    .cause_ovf      (cause_ovf),
    .exl            (exl),
    .double_fault   (double_fault),
    .trap_cnt       (trap_cnt)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic o, input logic en,
                       input logic [31:0] pc, input logic er, input logic st);
    ex_valid = v; ex_ovf = o; ex_ovf_en = en; ex_pc = pc; ex_eret = er; stall = st;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // From IDLE: take a trap at pc, end in HANDLER.
  task automatic do_trap(input logic [31:0] pc);
    drive(1'b1, 1'b1, 1'b1, pc, 1'b0, 1'b0);
    tick();
    idle_inputs();
    tick();
  endtask

  // From HANDLER: ERET, end in IDLE.
  task automatic do_eret();
    drive(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cnt_before;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_exl", 32'(exl), 32'd0);
    chk("rst_cnt", 32'(trap_cnt), 32'd0);
    chk("rst_flushes", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'd0);
    chk("rst_cause_df", 32'({cause_ovf, double_fault}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: signed overflow at 0x100 traps to the handler vector.
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    sample();
    chk("t1_kill", 32'(kill_ex_wb), 32'd1);
    chk("t1_no_redirect_t", 32'(redirect_valid), 32'd0);
    tick();
    idle_inputs();
    sample();
    chk("t1_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("t1_redirect_pc", redirect_pc, 32'h180);
    chk("t1_flushes", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'b111);
    chk("t1_epc", epc, 32'h100);
    chk("t1_exl", 32'(exl), 32'd1);
    chk("t1_cause", 32'(cause_ovf), 32'd1);
    chk("t1_cnt", 32'(trap_cnt), 32'd1);
    tick();
    sample();
    chk("t1_handler_strobes", 32'({redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem}), 32'd0);
    chk("t1_handler_pc", redirect_pc, 32'h0);

    // 2: ERET returns to epc+4 without flushing EX/MEM.
    drive(1'b1, 1'b0, 1'b0, 32'h180, 1'b1, 1'b0);
    tick();
    idle_inputs();
    sample();
    chk("t2_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("t2_redirect_pc", redirect_pc, 32'h104);
    chk("t2_flushes", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'b110);
    chk("t2_exl_in_return", 32'(exl), 32'd1);
    tick();
    sample();
    chk("t2_exl", 32'(exl), 32'd0);
    chk("t2_idle_strobes", 32'({redirect_valid, flush_if_id}), 32'd0);
    chk("t2_cause_kept", 32'(cause_ovf), 32'd1);
    // ERET in IDLE is ignored.
    drive(1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0);
    tick();
    idle_inputs();
    sample();
    chk("t2_idle_eret", 32'(redirect_valid), 32'd0);

    // 3: stalled overflow is killed each cycle but trapped only after stall drops.
    drive(1'b1, 1'b1, 1'b1, 32'h140, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("t3_kill_%0d", i), 32'(kill_ex_wb), 32'd1);
      chk($sformatf("t3_no_redirect_%0d", i), 32'(redirect_valid), 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    idle_inputs();
    sample();
    chk("t3_redirect", 32'(redirect_valid), 32'd1);
    chk("t3_cnt", 32'(trap_cnt), 32'd2);
    chk("t3_epc", epc, 32'h140);
    tick();
    do_eret();

    // 4: addu overflow does not trap.
    drive(1'b1, 1'b1, 1'b0, 32'h160, 1'b0, 1'b0);
    sample();
    chk("t4_kill", 32'(kill_ex_wb), 32'd0);
    tick();
    idle_inputs();
    sample();
    chk("t4_no_redirect", 32'(redirect_valid), 32'd0);
    chk("t4_cnt", 32'(trap_cnt), 32'd2);
    chk("t4_exl", 32'(exl), 32'd0);

    // 5: overflow inside the handler is a double fault, not a trap.
    do_trap(32'h100);
    drive(1'b1, 1'b1, 1'b1, 32'h184, 1'b0, 1'b0);
    sample();
    chk("t5_kill", 32'(kill_ex_wb), 32'd1);
    tick();
    idle_inputs();
    sample();
    chk("t5_df", 32'(double_fault), 32'd1);
    chk("t5_epc", epc, 32'h100);
    chk("t5_no_redirect", 32'(redirect_valid), 32'd0);
    chk("t5_cnt", 32'(trap_cnt), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 32'h188, 1'b1, 1'b0);
    tick();
    idle_inputs();
    sample();
    chk("t5_eret_prio", 32'(redirect_valid), 32'd1);
    chk("t5_eret_pc", redirect_pc, 32'h104);
    tick();

    // 6: counter saturates; async reset mid-handler clears everything.
    for (int i = 0; i < 252; i++) begin
      do_trap(32'h1000 + 32'(i * 4));
      do_eret();
    end
    sample();
    chk("t6_cnt_ff", 32'(trap_cnt), 32'hFF);
    cnt_before = trap_cnt;
    drive(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    idle_inputs();
    sample();
    chk("t6_cnt_sat", 32'(trap_cnt), 32'(cnt_before));
    chk("t6_epc", epc, 32'h400);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_exl", 32'(exl), 32'd0);
    chk("t6_rst_epc", epc, 32'h0);
    chk("t6_rst_cnt", 32'(trap_cnt), 32'd0);
    chk("t6_rst_df_cause", 32'({double_fault, cause_ovf}), 32'd0);
    chk("t6_rst_strobes", 32'({redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem, kill_ex_wb}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // Back in IDLE: a fresh trap is taken (ERET would be ignored otherwise).
    do_trap(32'h500);
    sample();
    chk("t6_post_rst_exl", 32'(exl), 32'd1);
    chk("t6_post_rst_cnt", 32'(trap_cnt), 32'd1);
    chk("t6_post_rst_epc", epc, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ovf_trap_ctrl.md
Name: ovf_trap_ctrl

Overview:
Consumes the per-instruction overflow flag produced in EX and turns it into a precise arithmetic-overflow exception.
- Kills the faulting instruction's writeback.
- Flushes younger pipeline stages.
- Records EPC and cause, and redirects fetch to the handler vector.
- On ERET, returns fetch to EPC+4.
Sits beside the EX stage; outputs drive the PC mux and the IF/ID, ID/EX and EX/MEM flush inputs.

Parameters:
PC_WIDTH, 32, width of PC and EPC
HANDLER_VEC, 32'h0000_0180, fetch address of the exception handler
CNT_WIDTH, 8, width of the saturating trap counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_ovf  in  1  overflow flag for the EX instruction (signed add/sub/addi result)
ex_ovf_en  in  1  EX instruction is a trapping op (add/sub/addi); 0 for addu/subu/addiu
ex_pc  in  PC_WIDTH  PC of the EX instruction
ex_eret  in  1  EX instruction is ERET
stall  in  1  pipeline stall from hazard unit; EX contents held
kill_ex_wb  out  1  clear RegWrite/MemWrite of the EX instruction entering EX/MEM
redirect_valid  out  1  PC mux override, one cycle
redirect_pc  out  PC_WIDTH  override target
flush_if_id  out  1  clear IF/ID
flush_id_ex  out  1  clear ID/EX
flush_ex_mem  out  1  clear EX/MEM
epc  out  PC_WIDTH  PC of faulting instruction
cause_ovf  out  1  last exception was overflow
exl  out  1  exception level; handler running
double_fault  out  1  sticky; overflow seen while exl=1
trap_cnt  out  CNT_WIDTH  saturating count of taken traps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; epc=0; cause_ovf=0; exl=0; double_fault=0; trap_cnt=0.
  - All strobes 0; redirect_pc=0.
- ovf_hit = ex_valid & ex_ovf & ex_ovf_en.
- kill_ex_wb: combinational, = ovf_hit in any state, including during stall.
- States IDLE, TRAP, HANDLER, RETURN (registered, binary encoded).
- IDLE:
  - If ovf_hit & ~stall: go to TRAP at the next edge.
  - On the same edge: epc<=ex_pc, cause_ovf<=1, exl<=1, trap_cnt<=trap_cnt+1 (saturates at all-ones).
  - If stall=1: no transition; the trap is taken in the first cycle stall=0.
  - ex_eret in IDLE is ignored.
- TRAP (exactly 1 cycle):
  - redirect_valid=1, redirect_pc=HANDLER_VEC.
  - flush_if_id=flush_id_ex=flush_ex_mem=1.
  - EX inputs ignored; the EX instruction is younger and is being flushed.
  - Next state HANDLER unconditionally; stall does not extend TRAP.
- HANDLER:
  - Strobes 0.
  - If ovf_hit: kill_ex_wb only, no trap, double_fault<=1; epc and trap_cnt unchanged.
  - If ex_valid & ex_eret & ~stall: go to RETURN. ERET has priority if asserted with ovf_hit.
- RETURN (exactly 1 cycle):
  - redirect_valid=1, redirect_pc=epc+4 (modulo 2^PC_WIDTH).
  - flush_if_id=flush_id_ex=1; flush_ex_mem=0, so ERET itself retires as a no-op.
  - exl<=0 at the exit edge; next state IDLE.
- redirect_pc=0 whenever redirect_valid=0.
- Latency: detect in cycle t, redirect/flush in cycle t+1, handler fetch in cycle t+2.
- cause_ovf holds until the next trap; it is never cleared by ERET.

Decomposition:
- Package ovf_trap_pkg:
  - state encoding constants (IDLE/TRAP/HANDLER/RETURN)
  - default HANDLER_VEC
  - cause code EXC_OV=5'd12
  - ERET return offset constant 4
- Saturating counter as sub-module sat_counter (WIDTH param, inc, clear via rst_n).
- Everything else stays in one module.

Test Plan:
1. IDLE, ex_valid=1, ovf_en=1, ovf=1 (0x7FFFFFFF+1), pc=0x100 -> cycle t: kill_ex_wb=1; cycle t+1: redirect_valid=1, redirect_pc=0x180, three flushes=1, epc=0x100, exl=1, trap_cnt=1.
2. From HANDLER, ex_eret=1 -> next cycle: redirect_pc=0x104, flush_if_id=flush_id_ex=1, flush_ex_mem=0; following cycle: exl=0, state IDLE.
3. ovf_hit held with stall=1 for 3 cycles -> kill_ex_wb=1 each cycle, no redirect; stall drops -> TRAP next cycle, trap_cnt incremented once.
4. ovf=1, ovf_en=0 (addu 0x7FFFFFFF+1) -> kill_ex_wb=0, no state change, trap_cnt unchanged.
5. In HANDLER, ovf_hit at pc=0x184 -> kill_ex_wb=1, double_fault=1, epc stays 0x100, no redirect; an ex_eret asserted with ovf_hit -> RETURN taken.
6. 256 traps/erets -> trap_cnt saturates at 0xFF. rst_n=0 asserted mid-HANDLER (not on an edge) -> all outputs 0 immediately, exl=0, state IDLE.
